beta_store: RTL and testbench

//  Parametrised register bank for intermediate beta_k values in the Itoh-Tsuji inversion datapath.
//  - One independent write port and one independent read port; both can be used in the same cycle.
//  - Registered read with a valid flag, plus per-entry written flags.
//  - Synchronous clear restarts the bank between inversions.
//  - Entry 0 holds the field identity (one) after reset or clear.

---
 rtl/ff_inv_pkg.sv | 11 +
 rtl/beta_store_rd.sv | 57 +++++
 rtl/beta_store.sv | 106 ++++++++++
 tb/tb_beta_store.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_inv_pkg.sv
// Shared field-element definitions for the Itoh-Tsuji inversion datapath.
package ff_inv_pkg;

  localparam int FF_WIDTH = 8;

  typedef logic [FF_WIDTH-1:0] elem_t;

  // Multiplicative identity of the field.
  localparam elem_t ONE = {{(FF_WIDTH-1){1'b0}}, 1'b1};

endpackage

// File: rtl/beta_store_rd.sv
// Read-path register stage of beta_store: registered data, valid and error flags,
// with a forwarding mux for same-cycle writes.
module beta_store_rd #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             rd_en,
  input  logic             rd_in_range,
  input  logic             rd_written,
  input  logic [WIDTH-1:0] rd_word,
  input  logic             byp_hit,
  input  logic [WIDTH-1:0] byp_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err
);

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;

  // rd_data holds across idle cycles; valid and err only describe the last read.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    rd_err_d   = 1'b0;
    if (rd_en) begin
      if (byp_hit) begin
        rd_data_d = byp_data;
      end else if (!rd_in_range) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_data_d = rd_word;
        rd_err_d  = !rd_written;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule

// File: rtl/beta_store.sv
// Register bank for intermediate beta_k values; entry 0 holds ONE after reset/clear.
// Same-address read/write forwarding is enabled by defining BETA_STORE_BYPASS_EN.
module beta_store
  import ff_inv_pkg::*;
#(
  parameter int WIDTH = FF_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  output logic [DEPTH-1:0] ent_valid
);

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(ONE);
  localparam logic [DEPTH-1:0] ENT_RST = DEPTH'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [DEPTH-1:0] wr_hit, rd_hit;
  logic [WIDTH-1:0] rd_word;
  logic             rd_in_range, rd_written, byp_hit;

  // One-hot address decode; out-of-range addresses decode to all zeros,
  // so dropped writes and error reads need no separate range compare.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = wr_en && (wr_addr == AW'(i));
      rd_hit[i] = (rd_addr == AW'(i));
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_hit[i]) rd_word = mem_q[i];
    end
  end

  assign rd_in_range = |rd_hit;
  assign rd_written  = |(rd_hit & ent_valid_q);

  // Clear wins over a same-cycle write.
  always_comb begin
    ent_valid_d = ent_valid_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (clr) begin
      ent_valid_d = ENT_RST;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = (i == 0) ? ONE_W : '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem_d[i]       = wr_data;
          ent_valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent_valid_q <= ENT_RST;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= (i == 0) ? ONE_W : '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef BETA_STORE_BYPASS_EN
  assign byp_hit = rd_en && !clr && |(wr_hit & rd_hit);
`else
  assign byp_hit = 1'b0;
`endif

  beta_store_rd #(
    .WIDTH(WIDTH)
  ) u_rd (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .rd_en      (rd_en),
    .rd_in_range(rd_in_range),
    .rd_written (rd_written),
    .rd_word    (rd_word),
    .byp_hit    (byp_hit),
    .byp_data   (wr_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err)
  );

  assign ent_valid = ent_valid_q;

endmodule

// File: tb/tb_beta_store.sv
// Bench for beta_store: directed table, DEPTH=3 range corner, reset mid-read,
// and randomized traffic against an array-based reference model.
module tb_beta_store;

`ifdef BETA_STORE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;

  // DEPTH=4 instance
  logic       clr = 0, wr_en = 0, rd_en = 0;
  logic [1:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data;
  logic       rd_valid, rd_err;
  logic [3:0] ent_valid;

  // DEPTH=3 instance
  logic       t_clr = 0, t_wr_en = 0, t_rd_en = 0;
  logic [1:0] t_wr_addr = 0, t_rd_addr = 0;
  logic [7:0] t_wr_data = 0;
  logic [7:0] t_rd_data;
  logic       t_rd_valid, t_rd_err;
  logic [2:0] t_ent_valid;

  beta_store #(.WIDTH(8), .DEPTH(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .ent_valid(ent_valid)
  );

  beta_store #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .clr(t_clr),
    .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_data(t_wr_data),
    .rd_en(t_rd_en), .rd_addr(t_rd_addr),
    .rd_data(t_rd_data), .rd_valid(t_rd_valid), .rd_err(t_rd_err), .ent_valid(t_ent_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [4];
  bit         m_wr  [4];
  logic [7:0] m_data;
  logic       m_valid, m_err;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = (i == 0) ? 8'h01 : 8'h00;
      m_wr[i]  = (i == 0);
    end
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic logic [3:0] model_ent();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = m_wr[i];
    return e;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  function automatic void model_step(input logic c, input logic we, input logic [1:0] wa,
                                     input logic [7:0] wd, input logic re, input logic [1:0] ra);
    m_valid = re;
    m_err   = 1'b0;
    if (re) begin
      if (BYP && we && !c && wa == ra) begin
        m_data = wd;
      end else begin
        m_data = m_mem[ra];
        m_err  = !m_wr[ra];
      end
    end
    if (c) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[i] = (i == 0) ? 8'h01 : 8'h00;
        m_wr[i]  = (i == 0);
      end
    end else if (we) begin
      m_mem[wa] = wd;
      m_wr[wa]  = 1'b1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic we, input logic [1:0] wa,
                       input logic [7:0] wd, input logic re, input logic [1:0] ra);
    @(negedge CLK);
    clr = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive3(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic re, input logic [1:0] ra);
    @(negedge CLK);
    t_clr = 1'b0; t_wr_en = we; t_wr_addr = wa; t_wr_data = wd; t_rd_en = re; t_rd_addr = ra;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       c, we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [1:0] ra;
    logic [7:0] e_data;
    logic       e_valid, e_err;
    logic [3:0] e_ent;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic c, input logic we, input logic [1:0] wa,
                              input logic [7:0] wd, input logic re, input logic [1:0] ra,
                              input logic [7:0] e_data, input logic e_valid,
                              input logic e_err, input logic [3:0] e_ent);
    vec_t v;
    v.c = c; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.e_data = e_data; v.e_valid = e_valid; v.e_err = e_err; v.e_ent = e_ent;
    return v;
  endfunction

  initial begin
    logic c, we, re;
    logic [1:0] wa, ra;
    logic [7:0] wd;

    //              c  we wa  wd     re ra  data   v  err ent
    tbl[0]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h01, 1, 0, 4'b0001);
    tbl[1]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h00, 1, 1, 4'b0001);
    tbl[2]  = mk(0, 0, 0, 8'h00, 1, 2, 8'h00, 1, 1, 4'b0001);
    tbl[3]  = mk(0, 0, 0, 8'h00, 1, 3, 8'h00, 1, 1, 4'b0001);
    tbl[4]  = mk(0, 1, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 4'b0011);
    tbl[5]  = mk(0, 0, 0, 8'h00, 1, 1, 8'hA5, 1, 0, 4'b0011);
    if (BYP) tbl[6] = mk(0, 1, 2, 8'h3C, 1, 2, 8'h3C, 1, 0, 4'b0111);
    else     tbl[6] = mk(0, 1, 2, 8'h3C, 1, 2, 8'h00, 1, 1, 4'b0111);
    tbl[7]  = mk(0, 0, 0, 8'h00, 1, 2, 8'h3C, 1, 0, 4'b0111);
    tbl[8]  = mk(0, 1, 0, 8'h77, 0, 0, 8'h3C, 0, 0, 4'b0111);
    tbl[9]  = mk(1, 1, 3, 8'h55, 1, 0, 8'h77, 1, 0, 4'b0001);
    tbl[10] = mk(0, 0, 0, 8'h00, 1, 0, 8'h01, 1, 0, 4'b0001);
    tbl[11] = mk(0, 0, 0, 8'h00, 1, 3, 8'h00, 1, 1, 4'b0001);

    // Reset state
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data",  rd_data,   8'h00);
    chk("rst_valid", rd_valid,  1'b0);
    chk("rst_err",   rd_err,    1'b0);
    chk("rst_ent",   ent_valid, 4'b0001);
    chk("rst3_ent",  t_ent_valid, 3'b001);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed table (model follows along so random traffic starts in sync)
    for (int i = 0; i < 12; i++) begin
      model_step(tbl[i].c, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      drive(tbl[i].c, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      chk($sformatf("tbl%0d_data", i),  rd_data,   tbl[i].e_data);
      chk($sformatf("tbl%0d_valid", i), rd_valid,  tbl[i].e_valid);
      chk($sformatf("tbl%0d_err", i),   rd_err,    tbl[i].e_err);
      chk($sformatf("tbl%0d_ent", i),   ent_valid, tbl[i].e_ent);
    end
    drive(0, 0, 0, 8'h00, 0, 0);
    model_step(0, 0, 0, 8'h00, 0, 0);
    chk("idle_valid", rd_valid, 1'b0);
    chk("idle_err",   rd_err,   1'b0);
    chk("idle_hold",  rd_data,  8'h00);

    // DEPTH=3: address 3 is out of range
    drive3(0, 0, 8'h00, 1, 0);
    chk("d3_rd0_data", t_rd_data, 8'h01);
    chk("d3_rd0_err",  t_rd_err,  1'b0);
    drive3(1, 3, 8'hFF, 1, 3);
    chk("d3_oor_data",  t_rd_data,   8'h00);
    chk("d3_oor_valid", t_rd_valid,  1'b1);
    chk("d3_oor_err",   t_rd_err,    1'b1);
    chk("d3_oor_ent",   t_ent_valid, 3'b001);
    drive3(0, 0, 8'h00, 1, 2);
    chk("d3_rd2_err",  t_rd_err,    1'b1);
    chk("d3_rd2_ent",  t_ent_valid, 3'b001);
    drive3(0, 0, 8'h00, 0, 0);
    chk("d3_idle_err", t_rd_err, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 15) == 0);
      we = $urandom_range(0, 1);
      wa = 2'($urandom_range(0, 3));
      wd = 8'($urandom_range(0, 255));
      re = ($urandom_range(0, 9) < 6);
      ra = ($urandom_range(0, 3) == 0) ? wa : 2'($urandom_range(0, 3));
      model_step(c, we, wa, wd, re, ra);
      exp_q.push_back(m_data);
      drive(c, we, wa, wd, re, ra);
      chk("rnd_data",  rd_data,   exp_q.pop_front());
      chk("rnd_valid", rd_valid,  m_valid);
      chk("rnd_err",   rd_err,    m_err);
      chk("rnd_ent",   ent_valid, model_ent());
    end

    // Reset asserted between rd_en and the next edge
    drive(0, 1, 0, 8'hA5, 0, 0);
    drive(0, 0, 0, 8'h00, 1, 0);
    chk("pre_rst_data",  rd_data,  8'hA5);
    chk("pre_rst_valid", rd_valid, 1'b1);
    @(negedge CLK);
    rd_en = 1'b1; rd_addr = 2'd1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h99;
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", rd_valid,  1'b0);
    chk("mid_rst_data",  rd_data,   8'h00);
    chk("mid_rst_err",   rd_err,    1'b0);
    chk("mid_rst_ent",   ent_valid, 4'b0001);
    @(negedge CLK);
    rd_en = 1'b0; wr_en = 1'b0;
    RST_N = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    chk("post_rst_valid", rd_valid, 1'b0);
    drive(0, 0, 0, 8'h00, 1, 0);
    chk("post_rst_rd0",  rd_data, 8'h01);
    chk("post_rst_err",  rd_err,  1'b0);
    drive(0, 0, 0, 8'h00, 1, 2);
    chk("post_rst_rd2_err", rd_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
